// File: rtl/arbitrated_memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the arbitrated memory block: default geometry,
// controller state encoding and the port identifiers held in the round-robin
// pointer.
// -----------------------------------------------------------------------------
package memory_pkg;

  localparam int DEFAULT_WORD_SIZE     = 16;
  localparam int DEFAULT_MEM_SIZE      = 128;
  localparam int DEFAULT_MEM_ADDR_SIZE = 8;

  // CLEAR: array being zeroed after reset; RUN: serving requests
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Values of the round-robin pointer, naming the port that wins a tie
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/arbitrated_memory_if.sv
// -----------------------------------------------------------------------------
// arbitrated_memory_if
// One request/response port of the arbitrated memory.
//   req_valid/req_ready : request handshake, accepted when both are high
//   write               : 1 = write, 0 = read
//   address, data_in    : request fields, held stable until accepted
//   resp_valid          : one-cycle response pulse
//   data_out, error     : response payload, held between responses
// Modports: master = requester, slave = memory.
// -----------------------------------------------------------------------------
interface arbitrated_memory_if
  import memory_pkg::*;
#(
  parameter int WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEFAULT_MEM_ADDR_SIZE
) ();

  logic                     req_valid;
  logic                     req_ready;
  logic                     write;
  logic [MEM_ADDR_SIZE-1:0] address;
  logic [WORD_SIZE-1:0]     data_in;
  logic                     resp_valid;
  logic [WORD_SIZE-1:0]     data_out;
  logic                     error;

  modport master (
    output req_valid, write, address, data_in,
    input  req_ready, resp_valid, data_out, error
  );

  modport slave (
    input  req_valid, write, address, data_in,
    output req_ready, resp_valid, data_out, error
  );

endinterface

// File: rtl/arbitrated_memory_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req[1:0]     : request lines, bit 0 = port A, bit 1 = port B
//   enable       : arbitration allowed this cycle
//   grant[1:0]   : combinational one-hot grant
// The pointer only moves on contention, so a lone requester never disturbs
// the turn order.
// -----------------------------------------------------------------------------
module rr_arbiter_2
  import memory_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic rr_pointer_r;

  // Grant selection from the request pattern and the tie-break pointer
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (rr_pointer_r == PORT_A) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

  // Tie-break pointer: hands the next tie to the port that just lost
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer_r <= PORT_A;
    end else if (enable && (req == 2'b11)) begin
      rr_pointer_r <= ~rr_pointer_r;
    end
  end

endmodule

// File: rtl/arbitrated_memory.sv
// -----------------------------------------------------------------------------
// arbitrated_memory
// Two-port word memory with round-robin arbitration and a post-reset clear.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   busy         : high while the array is being zeroed after reset
//   a, b         : request ports (slave side of arbitrated_memory_if)
// One access per cycle. A granted request gets a one-cycle-latency response
// carrying the word's previous contents (read-before-write). Addresses at or
// beyond MEM_SIZE return error with zero data and never touch the array.
// The array has no reset so it can map onto block RAM; the clear sequencer
// zeroes it one word per cycle instead.
// -----------------------------------------------------------------------------
module arbitrated_memory
  import memory_pkg::*;
#(
  parameter int WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int MEM_SIZE      = DEFAULT_MEM_SIZE,
  parameter int MEM_ADDR_SIZE = DEFAULT_MEM_ADDR_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 busy,
  arbitrated_memory_if.slave   a,
  arbitrated_memory_if.slave   b
);

  localparam int                       IDX_W     = $clog2(MEM_SIZE);
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = MEM_ADDR_SIZE'(MEM_SIZE - 1);
  // One extra bit so MEM_SIZE == 2**MEM_ADDR_SIZE is representable
  localparam logic [MEM_ADDR_SIZE:0]   SIZE_EXT  = (MEM_ADDR_SIZE + 1)'(MEM_SIZE);

  state_t                   state_r, state_next_s;
  logic [MEM_ADDR_SIZE-1:0] clear_ptr_r, clear_ptr_next_s;
  logic                     busy_r, busy_next_s;

  logic                     run_s;
  logic [1:0]               req_s, grant_s;
  logic                     sel_write_s;
  logic [MEM_ADDR_SIZE-1:0] sel_addr_s;
  logic [WORD_SIZE-1:0]     sel_data_s;
  logic                     in_range_s;
  logic [IDX_W-1:0]         rd_idx_s;

  logic                     mem_we_s;
  logic [IDX_W-1:0]         mem_idx_s;
  logic [WORD_SIZE-1:0]     mem_wdata_s;
  logic [WORD_SIZE-1:0]     mem_r [MEM_SIZE];

  logic                     a_resp_valid_r, b_resp_valid_r;
  logic [WORD_SIZE-1:0]     a_data_out_r, b_data_out_r;
  logic                     a_error_r, b_error_r;

  // Readies must drop in the very cycle reset is high, so gate on reset too
  assign run_s = (state_r == RUN) && !reset;
  assign req_s = {b.req_valid, a.req_valid};

  rr_arbiter_2 u_arbiter (
    .clock  (clock),
    .reset  (reset),
    .req    (req_s),
    .enable (run_s),
    .grant  (grant_s)
  );

  assign a.req_ready = grant_s[0];
  assign b.req_ready = grant_s[1];

  // Controller state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= CLEAR;
      clear_ptr_r <= {MEM_ADDR_SIZE{1'b0}};
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      clear_ptr_r <= clear_ptr_next_s;
      busy_r      <= busy_next_s;
    end
  end

  // Controller next state: walk the clear pointer up to the last word
  always_comb begin
    state_next_s     = state_r;
    clear_ptr_next_s = clear_ptr_r;
    busy_next_s      = busy_r;
    case (state_r)
      CLEAR: begin
        if (clear_ptr_r == LAST_ADDR) begin
          // Pointer parks here, so a full-range array never wraps it
          state_next_s = RUN;
          busy_next_s  = 1'b0;
        end else begin
          clear_ptr_next_s = clear_ptr_r + MEM_ADDR_SIZE'(1);
        end
      end
      RUN: begin
        busy_next_s = 1'b0;
      end
      default: begin
        state_next_s     = CLEAR;
        clear_ptr_next_s = {MEM_ADDR_SIZE{1'b0}};
        busy_next_s      = 1'b1;
      end
    endcase
  end

  // Request fields of whichever port holds the grant
  always_comb begin
    sel_write_s = a.write;
    sel_addr_s  = a.address;
    sel_data_s  = a.data_in;
    if (grant_s[1]) begin
      sel_write_s = b.write;
      sel_addr_s  = b.address;
      sel_data_s  = b.data_in;
    end else begin
      sel_write_s = a.write;
      sel_addr_s  = a.address;
      sel_data_s  = a.data_in;
    end
  end

  assign in_range_s = ({1'b0, sel_addr_s} < SIZE_EXT);
  assign rd_idx_s   = sel_addr_s[IDX_W-1:0];

  // Single array write port shared by the clear sequencer and granted writes
  always_comb begin
    mem_we_s    = 1'b0;
    mem_idx_s   = {IDX_W{1'b0}};
    mem_wdata_s = {WORD_SIZE{1'b0}};
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_we_s  = 1'b1;
      mem_idx_s = clear_ptr_r[IDX_W-1:0];
    end else if ((grant_s != 2'b00) && sel_write_s && in_range_s) begin
      mem_we_s    = 1'b1;
      mem_idx_s   = rd_idx_s;
      mem_wdata_s = sel_data_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array storage, deliberately without reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Response registers; the array read sees the pre-edge contents
  always_ff @(posedge clock) begin
    if (reset) begin
      a_resp_valid_r <= 1'b0;
      b_resp_valid_r <= 1'b0;
      a_data_out_r   <= {WORD_SIZE{1'b0}};
      b_data_out_r   <= {WORD_SIZE{1'b0}};
      a_error_r      <= 1'b0;
      b_error_r      <= 1'b0;
    end else begin
      a_resp_valid_r <= grant_s[0];
      b_resp_valid_r <= grant_s[1];
      if (grant_s[0]) begin
        a_data_out_r <= in_range_s ? mem_r[rd_idx_s] : {WORD_SIZE{1'b0}};
        a_error_r    <= !in_range_s;
      end
      if (grant_s[1]) begin
        b_data_out_r <= in_range_s ? mem_r[rd_idx_s] : {WORD_SIZE{1'b0}};
        b_error_r    <= !in_range_s;
      end
    end
  end

  assign busy         = busy_r;
  assign a.resp_valid = a_resp_valid_r;
  assign a.data_out   = a_data_out_r;
  assign a.error      = a_error_r;
  assign b.resp_valid = b_resp_valid_r;
  assign b.data_out   = b_data_out_r;
  assign b.error      = b_error_r;

endmodule
